// File: rtl/operand_read_if.sv
// Bundled ports of the operand_read stage: upstream instruction channel, register file
// read port, write-back broadcast and downstream operand channel.
// master: environment side (upstream, register file, write-back, downstream).
// slave:  the operand_read stage.
interface operand_read_if #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_WIDTH-1:0]    in_rs1;
  logic [ADDR_WIDTH-1:0]    in_rs2;
  logic [ADDR_WIDTH-1:0]    in_rd;
  logic                     in_wen;
  logic [PAYLOAD_WIDTH-1:0] in_payload;

  logic [ADDR_WIDTH-1:0]    rf_raddr1;
  logic [ADDR_WIDTH-1:0]    rf_raddr2;
  logic [DATA_WIDTH-1:0]    rf_rdata1;
  logic [DATA_WIDTH-1:0]    rf_rdata2;

  logic                     wb_valid;
  logic [ADDR_WIDTH-1:0]    wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_rs1_data;
  logic [DATA_WIDTH-1:0]    out_rs2_data;
  logic [ADDR_WIDTH-1:0]    out_rd;
  logic                     out_wen;
  logic [PAYLOAD_WIDTH-1:0] out_payload;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen, in_payload,
    input  in_ready,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    output wb_valid, wb_addr, wb_data,
    input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_wen, out_payload,
    output out_ready
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen, in_payload,
    output in_ready,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    input  wb_valid, wb_addr, wb_data,
    output out_valid, out_rs1_data, out_rs2_data, out_rd, out_wen, out_payload,
    input  out_ready
  );
endinterface

// File: rtl/operand_read.sv
// Issue-side operand fetch stage. Holds one decoded instruction, drives the register
// file read addresses, merges registered read data with a one-cycle write-back bypass
// and stalls the instruction while any of its sources has an in-flight producer.
// Optional: define OPERAND_READ_STALL_CNT_EN to add the 32-bit stall_cnt output.
module operand_read #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef OPERAND_READ_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  operand_read_if.slave bus
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic                     occ_q, occ_d;
  logic [ADDR_WIDTH-1:0]    rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0]    rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0]    rd_q, rd_d;
  logic                     wen_q, wen_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

  logic [NumRegs-1:0]       pend_q, pend_d;

  logic                     byp_valid_q;
  logic [ADDR_WIDTH-1:0]    byp_addr_q;
  logic [DATA_WIDTH-1:0]    byp_data_q;

  logic                     hazard;
  logic                     in_fire;
  logic                     out_fire;

  assign hazard        = ((rs1_q != '0) && pend_q[rs1_q]) || ((rs2_q != '0) && pend_q[rs2_q]);
  assign bus.out_valid = occ_q & ~hazard;
  assign out_fire      = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = ~occ_q | out_fire;
  assign in_fire       = bus.in_valid & bus.in_ready;

  // A new instruction reads its own sources; otherwise keep re-reading the held ones
  // so rf_rdata tracks any write-back that lands while we stall.
  assign bus.rf_raddr1 = in_fire ? bus.in_rs1 : rs1_q;
  assign bus.rf_raddr2 = in_fire ? bus.in_rs2 : rs2_q;

  assign bus.out_rd      = rd_q;
  assign bus.out_wen     = wen_q;
  assign bus.out_payload = payload_q;

  // Holding entry next state: load on accept, free on issue without replacement.
  always_comb begin
    occ_d     = occ_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    payload_d = payload_q;
    if (in_fire) begin
      occ_d     = 1'b1;
      rs1_d     = bus.in_rs1;
      rs2_d     = bus.in_rs2;
      rd_d      = bus.in_rd;
      wen_d     = bus.in_wen;
      payload_d = bus.in_payload;
    end else if (out_fire) begin
      occ_d = 1'b0;
    end
  end

  // Pending scoreboard: write-back clears, issue of a new producer sets (set wins).
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_valid && (bus.wb_addr != '0)) begin
      pend_d[bus.wb_addr] = 1'b0;
    end
    if (out_fire && wen_q && (rd_q != '0)) begin
      pend_d[rd_q] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Operand select: r0 is zero, last cycle's write-back beats the stale RAM read.
  always_comb begin
    bus.out_rs1_data = bus.rf_rdata1;
    bus.out_rs2_data = bus.rf_rdata2;
    if (rs1_q == '0) begin
      bus.out_rs1_data = '0;
    end else if (byp_valid_q && (byp_addr_q == rs1_q)) begin
      bus.out_rs1_data = byp_data_q;
    end
    if (rs2_q == '0) begin
      bus.out_rs2_data = '0;
    end else if (byp_valid_q && (byp_addr_q == rs2_q)) begin
      bus.out_rs2_data = byp_data_q;
    end
  end

  // Holding entry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      occ_q     <= occ_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      payload_q <= payload_d;
    end
  end

  // Pending bitvector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bypass register: capture the write-back every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= bus.wb_valid;
      byp_addr_q  <= bus.wb_addr;
      byp_data_q  <= bus.wb_data;
    end
  end

`ifdef OPERAND_READ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles spent holding an instruction blocked on a pending source; wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (occ_q && hazard) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_read.sv
// Bench for operand_read: directed scenarios followed by random traffic. A stimulus
// process pushes every accepted instruction into a queue; a monitor process keeps an
// architectural register array and a set of in-flight producers and checks the DUT
// outputs each cycle against them.
module tb_operand_read;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  operand_read_if bus ();

`ifdef OPERAND_READ_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned stall_m;
`endif

  operand_read dut (
    .clk       (clk),
    .rst       (rst),
`ifdef OPERAND_READ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] payload;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf_mem [32];
  logic [31:0] arch   [32];
  logic [31:0] outst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous register file: read returns the old value on a same-cycle write.
  always @(posedge clk) begin
    bus.rf_rdata1 <= rf_mem[bus.rf_raddr1];
    bus.rf_rdata2 <= rf_mem[bus.rf_raddr2];
    if (bus.wb_valid) rf_mem[bus.wb_addr] <= bus.wb_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record an accepted instruction.
  task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rdd, input logic w, input logic ordy,
                      input logic wv, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    bus.in_valid   = iv;
    bus.in_rs1     = r1;
    bus.in_rs2     = r2;
    bus.in_rd      = rdd;
    bus.in_wen     = w;
    bus.in_payload = $urandom;
    bus.out_ready  = ordy;
    bus.wb_valid   = wv;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      e.rs1     = r1;
      e.rs2     = r2;
      e.rd      = rdd;
      e.wen     = w;
      e.payload = bus.in_payload;
      e.cyc     = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ordy, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: compare against the architectural model, then advance the model.
  initial begin
    logic        held;
    logic        haz;
    logic        exp_valid;
    logic        exp_fire;
    logic [31:0] d1;
    logic [31:0] d2;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_rs1", bus.out_rs1_data, 32'd0);
        chk("rst_out_rs2", bus.out_rs2_data, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_wen", 32'(bus.out_wen), 32'd0);
        chk("rst_out_payload", bus.out_payload, 32'd0);
`ifdef OPERAND_READ_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        stall_m = 0;
`endif
        sb_q.delete();
        outst = '0;
        continue;
      end
      held      = (sb_q.size() > 0) && (sb_q[0].cyc < cyc);
      haz       = held && (((sb_q[0].rs1 != 0) && outst[sb_q[0].rs1]) ||
                           ((sb_q[0].rs2 != 0) && outst[sb_q[0].rs2]));
      exp_valid = held && !haz;
      exp_fire  = exp_valid && bus.out_ready;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!held || exp_fire));
      if (exp_valid) begin
        d1 = (sb_q[0].rs1 == 0) ? 32'd0 : arch[sb_q[0].rs1];
        d2 = (sb_q[0].rs2 == 0) ? 32'd0 : arch[sb_q[0].rs2];
        chk("out_rs1_data", bus.out_rs1_data, d1);
        chk("out_rs2_data", bus.out_rs2_data, d2);
        chk("out_rd", 32'(bus.out_rd), 32'(sb_q[0].rd));
        chk("out_wen", 32'(bus.out_wen), 32'(sb_q[0].wen));
        chk("out_payload", bus.out_payload, sb_q[0].payload);
      end
`ifdef OPERAND_READ_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stall_m);
      if (haz) stall_m++;
`endif
      if (bus.wb_valid) begin
        arch[bus.wb_addr] = bus.wb_data;
        if (bus.wb_addr != 0) outst[bus.wb_addr] = 1'b0;
      end
      if (exp_fire) begin
        if (sb_q[0].wen && (sb_q[0].rd != 0)) outst[sb_q[0].rd] = 1'b1;
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
`ifdef OPERAND_READ_STALL_CNT_EN
    logic [31:0] stall0;
`endif
    int guard;
    checks = 0;
    errors = 0;
    cyc    = 0;
    outst  = '0;
`ifdef OPERAND_READ_STALL_CNT_EN
    stall_m = 0;
`endif
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'd0;
      arch[i]   = 32'd0;
    end
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_wen     = 1'b0;
    bus.in_payload = '0;
    bus.out_ready  = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic read with r3 = 0x11 loaded by write-back.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h11);
    step(1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_rs1", bus.out_rs1_data, 32'h11);
    chk("basic_rs2", bus.out_rs2_data, 32'd0);
    chk("basic_in_ready", 32'(bus.in_ready), 32'd1);

    // RAW hazard on r5 released by a write-back through the bypass.
    step(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd5, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
`ifdef OPERAND_READ_STALL_CNT_EN
    stall0 = stall_cnt;
`endif
    chk("raw_stall0", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("raw_stall1", 32'(bus.out_valid), 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hAB);
    chk("raw_stall2", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("raw_release", 32'(bus.out_valid), 32'd1);
    chk("raw_bypass", bus.out_rs1_data, 32'hAB);
`ifdef OPERAND_READ_STALL_CNT_EN
    chk("raw_stall_cnt", stall_cnt - stall0, 32'd3);
`endif

    // Backpressure: held instruction stays put for 4 cycles.
    step(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_rd", 32'(bus.out_rd), 32'd4);
    end
    step(1'b1, 5'd0, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    idle(1'b1);
    chk("bp_next_rd", 32'(bus.out_rd), 32'd8);

    // Write-back to r0 never reaches a zero source.
    step(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFF);
    idle(1'b1);
    chk("r0_rs1", bus.out_rs1_data, 32'd0);

    // Issue of a producer of r7 coincides with a write-back to r7: r7 stays pending.
    step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77);
    step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    chk("setwin_stall", 32'(bus.out_valid), 32'd0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h78);
    idle(1'b1);
    chk("setwin_release", 32'(bus.out_valid), 32'd1);

    // Reset while an instruction is stalled on r6.
    step(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd6, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    chk("pre_rst_stall", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.wb_valid   = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 5'd6, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    chk("post_rst_no_pending", 32'(bus.out_valid), 32'd1);

    // Random traffic over a small register window to provoke hazards and bypasses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end

    // Drain: retire everything with write-backs, bounded.
    guard = 0;
    while (sb_q.size() > 0 && guard < 400) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'($urandom_range(1, 7)), $urandom);
      guard++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_read.md
Name: operand_read

Overview:
- Issue-side operand fetch stage; sits directly upstream of the register file.
- Accepts one decoded instruction per cycle and drives the register file read addresses.
- Merges the registered read data with a write-back bypass.
- Holds instructions whose sources are still pending in a register scoreboard, then presents complete operands downstream via valid/ready.

Parameters:
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH architectural registers, index 0 reads as zero
DATA_WIDTH, 32, register data width
PAYLOAD_WIDTH, 32, opaque decoded-instruction bits carried alongside operands

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_rs1  in  ADDR_WIDTH  source 1 index
in_rs2  in  ADDR_WIDTH  source 2 index
in_rd  in  ADDR_WIDTH  destination index
in_wen  in  1  instruction writes in_rd
in_payload  in  PAYLOAD_WIDTH  opaque bits
rf_raddr1  out  ADDR_WIDTH  register file read address 1
rf_raddr2  out  ADDR_WIDTH  register file read address 2
rf_rdata1  in  DATA_WIDTH  register file read data 1, valid one cycle after address
rf_rdata2  in  DATA_WIDTH  register file read data 2
wb_valid  in  1  write-back this cycle (same signals drive register file write port)
wb_addr  in  ADDR_WIDTH  write-back index
wb_data  in  DATA_WIDTH  write-back data
out_valid  out  1  operands complete
out_ready  in  1  downstream accepts
out_rs1_data  out  DATA_WIDTH  source 1 operand
out_rs2_data  out  DATA_WIDTH  source 2 operand
out_rd  out  ADDR_WIDTH  held destination
out_wen  out  1  held write flag
out_payload  out  PAYLOAD_WIDTH  held payload

Behaviour:
- State: one holding entry, consisting of an occupied bit, rs1, rs2, rd, wen and payload.
- State: a pending bitvector of 2**ADDR_WIDTH bits.
- State: a bypass register holding wb_valid, wb_addr and wb_data sampled every cycle.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = !occupied | out_fire (combinational).
- On in_fire the entry loads the in_* fields and occupied=1. On out_fire without in_fire, occupied=0.
- rf_raddr1/2 = in_rs1/2 on in_fire; otherwise the held rs1/rs2.
- Re-reading the held addresses every cycle keeps rf_rdata current while stalled.
- Register file read is synchronous and returns the old value on a same-cycle write. The bypass register covers this case.
- Source operand i is selected as follows:
  - held rs_i == 0: output 0.
  - else if bypass valid and bypass addr == rs_i: output bypass data.
  - else: output rf_rdata_i.
- hazard = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]), evaluated on the held entry.
- out_valid = occupied & !hazard.
- Minimum latency: accepted at cycle t, out_valid at t+1. Throughput is 1/cycle when there is no hazard and out_ready is high.
- Pending set: on out_fire with out_wen & out_rd!=0, set pending[out_rd].
- Pending clear: on wb_valid & wb_addr!=0, clear pending[wb_addr].
- Set and clear of the same index in the same cycle: set wins, because a new producer has been issued.
- pending[0] is never set.
- Hazard clear timing:
  - pending clears at the edge ending cycle t; hazard drops at t+1.
  - Data at t+1 comes through the bypass (wb registered at that edge).
  - From t+2 onward it comes from the register file.
- Held fields are stable while out_valid & !out_ready.
- Reset (any time, including mid-transfer) forces:
  - occupied=0, out_valid=0, in_ready=1.
  - pending all zero, bypass valid=0.
  - out_* data/fields=0.
- No instruction survives reset.

Optional Feature:
- Macro: OPERAND_READ_STALL_CNT_EN.
- When defined, add output stall_cnt (32 bits). It increments every cycle in which occupied & hazard; it wraps at 2**32-1 to 0 and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1 rs1=3 rs2=0 with rf holding r3=0x11 and out_ready=1 -> out_valid next cycle, out_rs1_data=0x11, out_rs2_data=0, in_ready stays 1.
- Issue A (rd=5, wen=1) and it fires; issue B (rs1=5) -> B out_valid=0 until wb_valid addr=5 data=0xAB. B out_valid the next cycle with out_rs1_data=0xAB via bypass.
- out_ready=0 for 4 cycles with an instruction held -> out_valid=1 and all out_* fields stable, in_ready=0. out_ready=1 -> fires once, then accepts next.
- wb_valid addr=0 data=0xFF while holding rs1=0 -> out_rs1_data=0, pending unchanged.
- out_fire with rd=7 in the same cycle as wb to 7 -> pending[7]=1 afterward; an instruction reading r7 stalls.
- Assert rst while held entry is stalled -> out_valid=0 and pending cleared immediately; with OPERAND_READ_STALL_CNT_EN, stall_cnt=0 after reset and counts 3 for a 3-cycle hazard.
